// File: rtl/md_pkg.sv
// Shared multiply/divide op codes and FSM states for the MD unit, control and stall decoding.
// is_md_long() flags the ops that occupy the unit for several cycles.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MFHI  = 3'd4,
      MD_MFLO  = 3'd5,
      MD_MTHI  = 3'd6,
      MD_MTLO  = 3'd7
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   function automatic logic is_md_long(input md_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO: MULT*/DIV* busy for a fixed cycle count, MTHI/MTLO in one cycle.
// Starts are ignored while busy (the stall unit holds D); cancel aborts without touching HI/LO.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             cancel,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] rd_data
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES) + 1;
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

   md_op_t           op_e;
   md_state_t        state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] hi_nxt, lo_nxt;
   logic [WIDTH-1:0] pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
   logic             pend_wr, pend_wr_nxt;

   logic               is_signed, is_div, b_zero, neg_a, neg_b, res_wr;
   logic [WIDTH-1:0]   mag_a, mag_b, divisor, quot, rem, div_q, div_r, res_hi, res_lo;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;

   assign op_e = md_op_t'(op);

   // Divide on magnitudes and fix signs afterwards; INT_MIN / -1 then wraps to INT_MIN rem 0.
   always_comb begin
      is_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
      is_div    = (op_e == MD_DIV)  || (op_e == MD_DIVU);
      b_zero    = (in_b == '0);
      ext_a     = is_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
      ext_b     = is_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};
      prod      = ext_a * ext_b;
      neg_a     = is_signed & in_a[WIDTH-1];
      neg_b     = is_signed & in_b[WIDTH-1];
      mag_a     = neg_a ? -in_a : in_a;
      mag_b     = neg_b ? -in_b : in_b;
      divisor   = b_zero ? WIDTH'(1) : mag_b;
      quot      = mag_a / divisor;
      rem       = mag_a % divisor;
      div_q     = (neg_a ^ neg_b) ? -quot : quot;
      div_r     = neg_a ? -rem : rem;
      res_hi    = is_div ? div_r : prod[2*WIDTH-1:WIDTH];
      res_lo    = is_div ? div_q : prod[WIDTH-1:0];
      res_wr    = !(is_div && b_zero);
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      hi_nxt      = hi;
      lo_nxt      = lo;
      pend_hi_nxt = pend_hi;
      pend_lo_nxt = pend_lo;
      pend_wr_nxt = pend_wr;
      if (cancel) begin
         state_nxt   = ST_IDLE;
         cnt_nxt     = '0;
         pend_wr_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (is_md_long(op_e)) begin
                     pend_hi_nxt = res_hi;
                     pend_lo_nxt = res_lo;
                     pend_wr_nxt = res_wr;
                     cnt_nxt     = is_div ? DIV_LOAD : MULT_LOAD;
                     state_nxt   = ST_RUN;
                  end else if (op_e == MD_MTHI) begin
                     hi_nxt = in_a;
                  end else if (op_e == MD_MTLO) begin
                     lo_nxt = in_a;
                  end
               end
            end
            ST_RUN: begin
               if (cnt == '0) begin
                  if (pend_wr) begin
                     hi_nxt = pend_hi;
                     lo_nxt = pend_lo;
                  end
                  pend_wr_nxt = 1'b0;
                  state_nxt   = ST_IDLE;
               end else begin
                  cnt_nxt = cnt - CW'(1);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         hi      <= hi_nxt;
         lo      <= lo_nxt;
         pend_hi <= pend_hi_nxt;
         pend_lo <= pend_lo_nxt;
         pend_wr <= pend_wr_nxt;
      end
   end

   assign busy    = (state == ST_RUN);
   assign rd_data = (op_e == MD_MFHI) ? hi : lo;

endmodule
